// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer
//
// Purpose:
//   Controller wrapped around a 1-bit serial full adder. A WIDTH-bit operand
//   pair is accepted over a valid/ready handshake and fed LSB-first through
//   the adder, one bit per clock. The sum is rebuilt in a right-shifting result
//   register. The sum and the final carry-out are then held on a valid/ready
//   output until the consumer takes them. Parallel datapaths can therefore
//   share a single bit-serial adder.
//
// Configuration:
//   SERIAL_ADD_SUB_EN  When defined, adds the in_sub port. A subtract request
//                      loads operand B inverted and starts the carry at 1, so
//                      the block computes A - B. out_carry then becomes the
//                      no-borrow flag (A >= B, unsigned).
//
// Parameters:
//   WIDTH      Operand/result width in bits (2 or more).
//
// Ports:
//   clk        Rising-edge clock.
//   rst        Synchronous reset, active-high.
//   in_valid   Operand pair valid.
//   in_ready   Block can accept operands (high only in IDLE).
//   in_a       Operand A.
//   in_b       Operand B.
//   in_sub     Subtract select (SERIAL_ADD_SUB_EN only).
//   out_valid  Result valid (high only in DONE).
//   out_ready  Consumer accepts the result.
//   out_sum    Result bits.
//   out_carry  Final carry-out, or the no-borrow flag when subtracting.
//
// Timing:
//   out_valid rises exactly WIDTH cycles after the accepting edge. The next
//   accept happens no earlier than one cycle after the output handshake.
// -----------------------------------------------------------------------------
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] count;

    // -------------------------------------------------------------------------
    // Serial full adder: one bit of each operand per clock.
    // -------------------------------------------------------------------------
    logic a_bit;
    logic b_bit;
    logic sum_bit;
    logic carry_next;

    assign a_bit      = a_sr[0];
    assign b_bit      = b_sr[0];
    assign sum_bit    = a_bit ^ b_bit ^ carry;
    assign carry_next = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);

    // -------------------------------------------------------------------------
    // Operand conditioning at accept time. Subtraction is A + ~B + 1. The +1
    // comes from starting the carry chain at 1, so no extra adder is needed.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] load_b;
    logic             load_carry;

`ifdef SERIAL_ADD_SUB_EN
    assign load_b     = in_sub ? ~in_b : in_b;
    assign load_carry = in_sub;
`else
    assign load_b     = in_b;
    assign load_carry = 1'b0;
`endif

    logic accept;
    logic last_edge;

    assign accept    = in_valid & in_ready;
    assign last_edge = (state == RUN) && (count == LAST_BIT);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values no matter how the always blocks are ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first. A path that
    // forgets an assignment would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (count == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand shifters, carry, bit counter, result register
    // -------------------------------------------------------------------------
    // NOTE: these registers are plain flops, not a memory array, so they all
    // take the synchronous reset. A reset mid-operation therefore also
    // discards every partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            if (accept) begin
                a_sr  <= in_a;
                b_sr  <= load_b;
                carry <= load_carry;
                count <= '0;
            end else if (state == RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                carry   <= carry_next;
                // The result fills from the top. After WIDTH shifts the
                // first sum bit has reached bit 0.
                out_sum <= {sum_bit, out_sum[WIDTH-1:1]};
                if (last_edge) begin
                    // The counter stops at WIDTH-1 and is cleared again on
                    // the next accept, so it never wraps.
                    out_carry <= carry_next;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sequencer
//
// Purpose:
//   Self-checking bench for serial_add_sequencer with WIDTH = 8. A table of
//   directed vectors is followed by hand-written multi-cycle sequences (reset
//   mid-run, back-to-back accepts). Randomised operations come last and are
//   compared against an arithmetic reference model.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef SERIAL_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        int           stall;
        logic [W-1:0] sum;
        logic         carry;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive and sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: plain arithmetic on whole operands.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
        logic [W-1:0] diff;
        if (sub) begin
            diff = a - b;
            return {(a >= b) ? 1'b1 : 1'b0, diff};
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Full transaction. Expects the DUT idle at a falling edge.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input int stall,
                          input logic [W-1:0] exp_sum, input logic exp_carry);
        int lat;
        check({name, " idle in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = (stall == 0);
        step();
        in_valid = 1'b0;
        // Later input changes must not affect the result.
        in_a   = W'($urandom);
        in_b   = W'($urandom);
        in_sub = ~sub;
        lat    = 0;
        while (!out_valid && lat < W + 4) begin
            step();
            lat++;
        end
        check({name, " latency"}, lat, W);
        check({name, " sum"}, {24'd0, out_sum}, {24'd0, exp_sum});
        check({name, " carry"}, {31'd0, out_carry}, {31'd0, exp_carry});
        for (int i = 0; i < stall; i++) begin
            step();
            check({name, " stall valid"}, {31'd0, out_valid}, 32'd1);
            check({name, " stall in_ready"}, {31'd0, in_ready}, 32'd0);
            check({name, " stall sum"}, {24'd0, out_sum}, {24'd0, exp_sum});
        end
        out_ready = 1'b1;
        step();
        check({name, " post valid"}, {31'd0, out_valid}, 32'd0);
        check({name, " post in_ready"}, {31'd0, in_ready}, 32'd1);
        check({name, " post sum held"}, {24'd0, out_sum}, {24'd0, exp_sum});
        out_ready = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W:0]   ref_res;
        int           lat;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, stall: 0, sum: 8'h96, carry: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, stall: 0, sum: 8'h00, carry: 1'b1};
        vecs[2] = '{a: 8'h5A, b: 8'h3C, sub: 1'b0, stall: 5, sum: 8'h96, carry: 1'b0};
        vecs[3] = '{a: 8'h00, b: 8'h00, sub: 1'b0, stall: 1, sum: 8'h00, carry: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_sum", {24'd0, out_sum}, 32'd0);
        check("reset out_carry", {31'd0, out_carry}, 32'd0);
        rst = 1'b0;
        step();

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].stall, vecs[i].sum, vecs[i].carry);
        end

        // Reset in the middle of a run
        in_valid = 1'b1;
        in_a     = 8'hAA;
        in_b     = 8'h55;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort out_sum", {24'd0, out_sum}, 32'd0);
        check("abort out_carry", {31'd0, out_carry}, 32'd0);
        for (int i = 0; i < W + 1; i++) step();
        check("abort stays idle", {31'd0, out_valid}, 32'd0);
        run_op("after abort", 8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0);

        // Back-to-back with in_valid held high and data changing
        in_valid  = 1'b1;
        in_a      = 8'h10;
        in_b      = 8'h20;
        out_ready = 1'b1;
        step();
        in_a = 8'h80;
        in_b = 8'h80;
        lat  = 0;
        while (!out_valid && lat < W + 4) begin
            step();
            lat++;
        end
        check("b2b first latency", lat, W);
        check("b2b first sum", {24'd0, out_sum}, 32'h30);
        check("b2b first carry", {31'd0, out_carry}, 32'd0);
        check("b2b no bypass", {31'd0, in_ready}, 32'd0);
        step();
        check("b2b idle after hs", {31'd0, in_ready}, 32'd1);
        step();
        check("b2b second accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < W + 4) begin
            step();
            lat++;
        end
        check("b2b second latency", lat, W);
        check("b2b second sum", {24'd0, out_sum}, 32'h00);
        check("b2b second carry", {31'd0, out_carry}, 32'd1);
        step();
        out_ready = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub 10-01", 8'h10, 8'h01, 1'b1, 0, 8'h0F, 1'b1);
        run_op("sub 01-02", 8'h01, 8'h02, 1'b1, 2, 8'hFF, 1'b0);
`endif

        // Randomised operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom_range(1, 0));
`else
            rs = 1'b0;
`endif
            ref_res = model(ra, rb, rs);
            run_op($sformatf("rand%0d", i), ra, rb, rs, int'($urandom_range(2, 0)),
                   ref_res[W-1:0], ref_res[W]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
